// File: rtl/arith_pipe_rotator_pkg.sv
// Shared op encoding and helpers for the pipelined rotate/shift unit.
// Op values 5..7 are reserved and pass the operand through unchanged.
package arith_pipe_rotator_pkg;

  localparam int ROT_OP_W = 3;

  typedef enum logic [ROT_OP_W-1:0] {
    ROT_ROL = 3'd0,
    ROT_ROR = 3'd1,
    ROT_SLL = 3'd2,
    ROT_SRL = 3'd3,
    ROT_SRA = 3'd4
  } rot_op_t;

  // Right-moving ops share the same datapath direction in every stage.
  function automatic logic is_right(input logic [ROT_OP_W-1:0] op);
    return (op == ROT_ROR) || (op == ROT_SRL) || (op == ROT_SRA);
  endfunction

  function automatic logic is_valid_op(input logic [ROT_OP_W-1:0] op);
    return op <= ROT_SRA;
  endfunction

endpackage

// File: rtl/arith_pipe_rotator_if.sv
// Issue-side and writeback-side handshake bundle for the rotator.
// master = producer/consumer around the unit, slave = the unit itself.
interface arith_pipe_rotator_if
  import arith_pipe_rotator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
);

  // Valid/ready: a transfer happens on a rising edge where val & rdy are both 1.
  // Once val is raised it stays high with stable payload until the transfer;
  // rdy may depend on the other side's state but never on the same-side val.
  logic                in_val;
  logic                in_rdy;
  logic [WIDTH-1:0]    in_data;
  logic [AMT_W-1:0]    in_amt;
  logic [ROT_OP_W-1:0] in_op;
  logic                out_val;
  logic                out_rdy;
  logic [WIDTH-1:0]    out_data;

  modport master (
    output in_val, in_data, in_amt, in_op, out_rdy,
    input  in_rdy, out_val, out_data
  );

  modport slave (
    input  in_val, in_data, in_amt, in_op, out_rdy,
    output in_rdy, out_val, out_data
  );

endinterface

// File: rtl/arith_pipe_rotator_stage.sv
// One combinational 2^k move of the rotate/shift pipe; SHIFT = 2^k.
// When en_i is clear, or the op is reserved, the data passes straight through.
module arith_pipe_rotator_stage
  import arith_pipe_rotator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0]    data_i,
  input  logic                en_i,
  input  logic [ROT_OP_W-1:0] op_i,
  output logic [WIDTH-1:0]    data_o
);

  logic [WIDTH-1:0] left_fill;
  logic [WIDTH-1:0] right_fill;

  // Fill bits are what enters the vacated end: wrapped bits for rotates,
  // copies of the current MSB for SRA, zeros for logical shifts.
  always_comb begin
    left_fill  = '0;
    right_fill = '0;
    case (op_i)
      ROT_ROL: left_fill  = data_i >> (WIDTH - SHIFT);
      ROT_ROR: right_fill = data_i << (WIDTH - SHIFT);
      ROT_SRA: right_fill = data_i[WIDTH-1] ? ~({WIDTH{1'b1}} >> SHIFT) : '0;
      default: ;
    endcase
  end

  always_comb begin
    data_o = data_i;
    if (en_i && is_valid_op(op_i)) begin
      if (is_right(op_i)) begin
        data_o = (data_i >> SHIFT) | right_fill;
      end else begin
        data_o = (data_i << SHIFT) | left_fill;
      end
    end
  end

endmodule

// File: rtl/arith_pipe_rotator.sv
// Pipelined WIDTH-bit rotate/shift unit: stage k applies the 2^k move selected
// by amt[k]. Elastic valid/ready chain squeezes bubbles ahead of a stall.
module arith_pipe_rotator
  import arith_pipe_rotator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                reset,
  arith_pipe_rotator_if.slave bus
);

  // Stage registers. The last stage keeps only val and data; its data is the
  // output register and is the only data register that gets reset.
  logic [AMT_W-1:0]    val_q;
  logic [WIDTH-1:0]    data_q [AMT_W-1];
  logic [AMT_W-1:0]    amt_q  [AMT_W-1];
  logic [ROT_OP_W-1:0] op_q   [AMT_W-1];
  logic [WIDTH-1:0]    out_data_q;

  // Per-stage inputs (what stage k sees before its register) and results.
  logic [AMT_W-1:0]    src_val;
  logic [WIDTH-1:0]    src_data [AMT_W];
  logic [AMT_W-1:0]    src_amt  [AMT_W];
  logic [ROT_OP_W-1:0] src_op   [AMT_W];
  logic [WIDTH-1:0]    data_d   [AMT_W];
  logic [AMT_W-1:0]    rdy;

  // Stage k can load when it is empty or the stage downstream is moving.
  always_comb begin : rdy_chain
    logic r;
    r   = bus.out_rdy;
    rdy = '0;
    for (int k = AMT_W - 1; k >= 0; k--) begin
      r      = !val_q[k] || r;
      rdy[k] = r;
    end
  end

  always_comb begin
    src_val[0]  = bus.in_val;
    src_data[0] = bus.in_data;
    src_amt[0]  = bus.in_amt;
    src_op[0]   = bus.in_op;
    for (int k = 1; k < AMT_W; k++) begin
      src_val[k]  = val_q[k-1];
      src_data[k] = data_q[k-1];
      src_amt[k]  = amt_q[k-1];
      src_op[k]   = op_q[k-1];
    end
  end

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    arith_pipe_rotator_stage #(
      .WIDTH (WIDTH),
      .SHIFT (1 << k)
    ) u_stage (
      .data_i (src_data[k]),
      .en_i   (src_amt[k][k]),
      .op_i   (src_op[k]),
      .data_o (data_d[k])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_q      <= '0;
      out_data_q <= '0;
    end else begin
      for (int k = 0; k < AMT_W; k++) begin
        if (rdy[k]) begin
          val_q[k] <= src_val[k];
        end
      end
      if (rdy[AMT_W-1] && src_val[AMT_W-1]) begin
        out_data_q <= data_d[AMT_W-1];
      end
    end
  end

  // Payload only moves with a valid op, so idle X operands never propagate.
  always_ff @(posedge clk) begin
    for (int k = 0; k < AMT_W - 1; k++) begin
      if (rdy[k] && src_val[k]) begin
        data_q[k] <= data_d[k];
        amt_q[k]  <= src_amt[k];
        op_q[k]   <= src_op[k];
      end
    end
  end

  assign bus.in_rdy   = rdy[0] & reset;
  assign bus.out_val  = val_q[AMT_W-1];
  assign bus.out_data = out_data_q;

endmodule

// File: tb/tb_arith_pipe_rotator.sv
// Bench for arith_pipe_rotator at WIDTH=8 (directed + random) and WIDTH=32 (random).
// Expected results come from a bit-level model of each op and an in-order queue.
module tb_arith_pipe_rotator;
  import arith_pipe_rotator_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [63:0] exp_q [2][$];
  int          fire_q [2][$];
  int          emitted [2];
  logic [63:0] out_log [$];
  int          out_cyc_log [$];
  int          in_cyc_log [$];

  logic [7:0] rol_exp [8] = '{8'h5D, 8'hBA, 8'h75, 8'hEA, 8'hD5, 8'hAB, 8'h57, 8'hAE};
  logic [7:0] d_data  [5] = '{8'hD5, 8'h5D, 8'h80, 8'h80, 8'h3C};
  int         d_amt   [5] = '{3, 4, 7, 7, 5};
  int         d_op    [5] = '{1, 2, 3, 4, 6};
  logic [7:0] d_exp   [5] = '{8'hBA, 8'hD0, 8'h01, 8'hFF, 8'h3C};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arith_pipe_rotator_if #(.WIDTH(8))  b8 ();
  arith_pipe_rotator_if #(.WIDTH(32)) b32 ();

  arith_pipe_rotator #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(b8.slave));
  arith_pipe_rotator #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .bus(b32.slave));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_calc(input logic [63:0] d, input int amt,
                                           input int op, input int w);
    logic [63:0] r = '0;
    for (int i = 0; i < w; i++) begin
      case (op)
        0:       r[(i + amt) % w] = d[i];
        1:       r[i] = d[(i + amt) % w];
        2:       r[i] = (i >= amt) ? d[i - amt] : 1'b0;
        3:       r[i] = (i + amt < w) ? d[i + amt] : 1'b0;
        4:       r[i] = (i + amt < w) ? d[i + amt] : d[w-1];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Pipe occupancy equals the expected-queue depth; the oldest op must be
  // presented once it is aw cycles old; the unit is full only with aw ops held.
  task automatic mon(input int id, input int w, input int aw,
                     input logic in_val, input logic in_rdy, input logic [63:0] in_data,
                     input int in_amt, input int in_op,
                     input logic out_val, input logic out_rdy, input logic [63:0] out_data);
    string tag;
    int    age;
    tag = (id == 0) ? "w8" : "w32";
    check({tag, "_in_rdy"}, in_rdy, !((exp_q[id].size() == aw) && !out_rdy));
    if (exp_q[id].size() == 0) begin
      check({tag, "_idle_out_val"}, out_val, 1'b0);
    end else begin
      age = cyc - fire_q[id][0];
      check({tag, "_out_val"}, out_val, age >= aw);
      if (out_val) begin
        check({tag, "_out_data"}, out_data, exp_q[id][0]);
        if (out_rdy) begin
          void'(exp_q[id].pop_front());
          void'(fire_q[id].pop_front());
          emitted[id]++;
        end
      end
    end
    if (id == 0 && out_val && out_rdy) begin
      out_log.push_back(out_data);
      out_cyc_log.push_back(cyc);
    end
    if (in_val && in_rdy) begin
      exp_q[id].push_back(ref_calc(in_data, in_amt, in_op, w));
      fire_q[id].push_back(cyc);
      if (id == 0) in_cyc_log.push_back(cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      mon(0, 8, 3, b8.in_val, b8.in_rdy, 64'(b8.in_data), int'(b8.in_amt), int'(b8.in_op),
          b8.out_val, b8.out_rdy, 64'(b8.out_data));
      mon(1, 32, 5, b32.in_val, b32.in_rdy, 64'(b32.in_data), int'(b32.in_amt),
          int'(b32.in_op), b32.out_val, b32.out_rdy, 64'(b32.out_data));
    end
  end

  // In-flight ops are discarded by reset, so their expectations go too.
  always @(negedge reset) begin
    for (int id = 0; id < 2; id++) begin
      exp_q[id].delete();
      fire_q[id].delete();
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] d, input int a, input int op);
    logic acc;
    int   n;
    b8.in_val  = 1'b1;
    b8.in_data = d;
    b8.in_amt  = a[2:0];
    b8.in_op   = op[2:0];
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = b8.in_rdy;
      n++;
      @(posedge clk);
      #1;
    end
    b8.in_val = 1'b0;
    check("w8_send_accept", acc, 1'b1);
  endtask

  task automatic clear_logs();
    out_log.delete();
    out_cyc_log.delete();
    in_cyc_log.delete();
  endtask

  task automatic rand8(input int nops, output int sent);
    int guard;
    guard = 0;
    sent  = 0;
    while (sent < nops && guard < 4000) begin
      b8.in_val = ($urandom_range(0, 3) != 0);
      if (b8.in_val) begin
        b8.in_data = 8'($urandom);
        b8.in_amt  = 3'($urandom_range(0, 7));
        b8.in_op   = 3'($urandom_range(0, 7));
      end else begin
        b8.in_data = 'x;
        b8.in_amt  = 'x;
        b8.in_op   = 'x;
      end
      b8.out_rdy = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (b8.in_val && b8.in_rdy) sent++;
      @(posedge clk);
      #1;
      guard++;
    end
    b8.in_val  = 1'b0;
    b8.out_rdy = 1'b1;
  endtask

  task automatic rand32(input int nops, output int sent);
    int guard;
    guard = 0;
    sent  = 0;
    while (sent < nops && guard < 4000) begin
      b32.in_val = ($urandom_range(0, 3) != 0);
      if (b32.in_val) begin
        b32.in_data = $urandom;
        b32.in_amt  = 5'($urandom_range(0, 31));
        b32.in_op   = 3'($urandom_range(0, 7));
      end else begin
        b32.in_data = 'x;
        b32.in_amt  = 'x;
        b32.in_op   = 'x;
      end
      b32.out_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (b32.in_val && b32.in_rdy) sent++;
      @(posedge clk);
      #1;
      guard++;
    end
    b32.in_val  = 1'b0;
    b32.out_rdy = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int sent8;
    int sent32;
    int acc_cnt;

    b8.in_val  = 1'b0; b8.in_data  = '0; b8.in_amt  = '0; b8.in_op  = '0; b8.out_rdy  = 1'b1;
    b32.in_val = 1'b0; b32.in_data = '0; b32.in_amt = '0; b32.in_op = '0; b32.out_rdy = 1'b1;
    reset = 1'b0;
    wait_cycles(2);
    check("rst_w8_out_val", b8.out_val, 1'b0);
    check("rst_w8_out_data", b8.out_data, 8'h00);
    check("rst_w8_in_rdy", b8.in_rdy, 1'b0);
    check("rst_w32_out_val", b32.out_val, 1'b0);
    check("rst_w32_in_rdy", b32.in_rdy, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    wait_cycles(1);
    check("post_rst_in_rdy", b8.in_rdy, 1'b1);

    // Hand-computed values that pin the model itself.
    for (int a = 0; a < 8; a++) check("model_rol", ref_calc(64'h5D, a, 0, 8), 64'(rol_exp[a]));
    for (int i = 0; i < 5; i++)
      check("model_misc", ref_calc(64'(d_data[i]), d_amt[i], d_op[i], 8), 64'(d_exp[i]));
    check("model_sra32", ref_calc(64'h8000_0000, 31, 4, 32), 64'hFFFF_FFFF);
    check("model_ror32", ref_calc(64'h0000_0001, 1, 1, 32), 64'h8000_0000);

    // ROL sweep, back-to-back.
    clear_logs();
    for (int a = 0; a < 8; a++) send8(8'h5D, a, int'(ROT_ROL));
    wait_cycles(6);
    check("rol_sweep_count", out_log.size(), 8);
    if (out_log.size() == 8 && in_cyc_log.size() == 8) begin
      for (int i = 0; i < 8; i++) check("rol_sweep_data", out_log[i], 64'(rol_exp[i]));
      check("rol_sweep_latency", out_cyc_log[0] - in_cyc_log[0], 3);
      for (int i = 1; i < 8; i++) check("rol_sweep_gap", out_cyc_log[i] - out_cyc_log[i-1], 1);
    end

    // Other ops, including a reserved code.
    clear_logs();
    for (int i = 0; i < 5; i++) send8(d_data[i], d_amt[i], d_op[i]);
    wait_cycles(6);
    check("misc_count", out_log.size(), 5);
    if (out_log.size() == 5) begin
      for (int i = 0; i < 5; i++) check("misc_data", out_log[i], 64'(d_exp[i]));
    end

    // Back-pressure: only AMT_W ops fit while the output is stalled.
    clear_logs();
    b8.out_rdy = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      b8.in_val  = 1'b1;
      b8.in_data = 8'h10 + 8'(i);
      b8.in_amt  = 3'd1;
      b8.in_op   = 3'(ROT_ROL);
      @(negedge clk);
      if (b8.in_rdy) acc_cnt++;
      @(posedge clk);
      #1;
    end
    check("bp_accept_count", acc_cnt, 3);
    check("bp_in_rdy_low", b8.in_rdy, 1'b0);
    check("bp_nothing_emitted", out_log.size(), 0);
    b8.in_val  = 1'b0;
    b8.out_rdy = 1'b1;
    wait_cycles(5);
    check("bp_count", out_log.size(), 3);
    if (out_log.size() == 3) begin
      check("bp_data0", out_log[0], 64'h20);
      check("bp_data1", out_log[1], 64'h22);
      check("bp_data2", out_log[2], 64'h24);
      check("bp_gap1", out_cyc_log[1] - out_cyc_log[0], 1);
      check("bp_gap2", out_cyc_log[2] - out_cyc_log[1], 1);
    end

    // Random traffic on both widths at once.
    emitted[0] = 0;
    emitted[1] = 0;
    fork
      rand8(200, sent8);
      rand32(200, sent32);
    join
    wait_cycles(20);
    check("w8_rand_sent", sent8, 200);
    check("w32_rand_sent", sent32, 200);
    check("w8_rand_emitted", emitted[0], 200);
    check("w32_rand_emitted", emitted[1], 200);
    check("w8_rand_drained", exp_q[0].size(), 0);
    check("w32_rand_drained", exp_q[1].size(), 0);

    // Reset with two ops in flight.
    send8(8'h11, 1, int'(ROT_ROL));
    send8(8'h22, 2, int'(ROT_ROL));
    #2 reset = 1'b0;
    #1;
    check("midrst_out_val", b8.out_val, 1'b0);
    check("midrst_out_data", b8.out_data, 8'h00);
    check("midrst_in_rdy", b8.in_rdy, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    clear_logs();
    wait_cycles(6);
    check("midrst_no_ghosts", out_log.size(), 0);
    send8(8'h01, 1, int'(ROT_ROL));
    wait_cycles(5);
    check("midrst_next_count", out_log.size(), 1);
    if (out_log.size() == 1 && in_cyc_log.size() == 1) begin
      check("midrst_next_data", out_log[0], 64'h02);
      check("midrst_next_latency", out_cyc_log[0] - in_cyc_log[0], 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
